pif_i2c_master: RTL and testbench

I2C initiator that drives transactions against the pif I2C register slave (`pifwb`/`pifctl`). It lets on-board logic or a test harness write and read pif registers, for example the LED-pattern `MiscReg`, over the same two-wire bus. A one-shot command port accepts each transaction. The block generates START, repeated-START and STOP, shifts bytes, handles slave clock stretching and reports ACK errors. It is single-master only, with no arbitration.

---
 rtl/pif_i2c_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_pif_i2c_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pif_i2c_master.sv
// Single-master I2C initiator: issues pif register writes and reads (reads use a
// repeated START), with slave clock stretching and ACK error reporting.
module pif_i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic       cmd_start,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, TXBYTE, RXACK, RESTART, RXBYTE, TXNACK, STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [1:0]    byteIdx_q, byteIdx_d;
  logic [7:0]    txShift_q, txShift_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic          rd_q, rd_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          nackSeen_q, nackSeen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ackErr_q, ackErr_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sclOe_q, sclOe_d;
  logic          sdaOe_q, sdaOe_d;
  logic [1:0]    sclSync_q, sdaSync_q;

  logic sclS, sdaS, running, freeze, sampleEdge, bitEnd;

  assign sclS = sclSync_q[1];
  assign sdaS = sdaSync_q[1];

  // The divider holds at the start of q2 while a slave stretches SCL low.
  always_comb begin
    running    = state_q inside {START, TXBYTE, RXACK, RESTART, RXBYTE, TXNACK, STOP};
    freeze     = (state_q inside {TXBYTE, RXACK, RXBYTE, TXNACK, STOP}) &&
                 (qtr_q == 2'd2) && (div_q == '0) && !sclS;
    sampleEdge = running && (qtr_q == 2'd2) && (div_q == DIV_LAST);
    bitEnd     = running && (qtr_q == 2'd3) && (div_q == DIV_LAST);
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bitCnt_d   = bitCnt_q;
    byteIdx_d  = byteIdx_q;
    txShift_d  = txShift_q;
    rxShift_d  = rxShift_q;
    rd_d       = rd_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    nackSeen_d = nackSeen_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ackErr_d   = ackErr_q;
    rdata_d    = rdata_q;

    if (running && !freeze) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    if (sampleEdge && state_q == RXACK) begin
      nackSeen_d = sdaS;
      if (sdaS) ackErr_d = 1'b1;
    end
    if (sampleEdge && state_q == RXBYTE) rxShift_d = {rxShift_q[6:0], sdaS};

    case (state_q)
      IDLE: if (cmd_start) begin
        state_d   = START;
        div_d     = '0;
        qtr_d     = '0;
        busy_d    = 1'b1;
        ackErr_d  = 1'b0;
        rd_d      = cmd_rd;
        dev_d     = cmd_dev;
        reg_d     = cmd_reg;
        wdata_d   = cmd_wdata;
        byteIdx_d = 2'd0;
        bitCnt_d  = 3'd7;
        txShift_d = {cmd_dev, 1'b0};
      end
      START: if (bitEnd) state_d = TXBYTE;
      TXBYTE: if (bitEnd) begin
        if (bitCnt_q == 3'd0) state_d = RXACK;
        else begin
          bitCnt_d  = bitCnt_q - 3'd1;
          txShift_d = {txShift_q[6:0], 1'b0};
        end
      end
      // A NACK on any byte skips whatever remains and closes with STOP.
      RXACK: if (bitEnd) begin
        bitCnt_d = 3'd7;
        if (nackSeen_q) state_d = STOP;
        else begin
          case (byteIdx_q)
            2'd0: begin
              state_d   = TXBYTE;
              txShift_d = reg_q;
              byteIdx_d = 2'd1;
            end
            2'd1: begin
              if (rd_q) state_d = RESTART;
              else begin
                state_d   = TXBYTE;
                txShift_d = wdata_q;
                byteIdx_d = 2'd2;
              end
            end
            default: state_d = rd_q ? RXBYTE : STOP;
          endcase
        end
      end
      RESTART: if (bitEnd) begin
        state_d   = TXBYTE;
        txShift_d = {dev_q, 1'b1};
        byteIdx_d = 2'd2;
        bitCnt_d  = 3'd7;
      end
      RXBYTE: if (bitEnd) begin
        if (bitCnt_q == 3'd0) begin
          state_d = TXNACK;
          rdata_d = rxShift_q;
        end else begin
          bitCnt_d = bitCnt_q - 3'd1;
        end
      end
      TXNACK: if (bitEnd) state_d = STOP;
      STOP:   if (bitEnd) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Line drive derived from the next state so the pins line up with the phase.
    sclOe_d = 1'b0;
    sdaOe_d = 1'b0;
    case (state_d)
      START:                 sdaOe_d = qtr_d[1];
      TXBYTE: begin
        sclOe_d = (qtr_d == 2'd0);
        sdaOe_d = !txShift_d[7];
      end
      RXACK, RXBYTE, TXNACK: sclOe_d = (qtr_d == 2'd0);
      RESTART: begin
        sclOe_d = (qtr_d == 2'd0);
        sdaOe_d = qtr_d[1];
      end
      STOP: begin
        sclOe_d = (qtr_d == 2'd0);
        sdaOe_d = (qtr_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge xclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      qtr_q      <= '0;
      bitCnt_q   <= 3'd7;
      byteIdx_q  <= '0;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      rd_q       <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      nackSeen_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ackErr_q   <= 1'b0;
      rdata_q    <= '0;
      sclOe_q    <= 1'b0;
      sdaOe_q    <= 1'b0;
      sclSync_q  <= 2'b11;
      sdaSync_q  <= 2'b11;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bitCnt_q   <= bitCnt_d;
      byteIdx_q  <= byteIdx_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      rd_q       <= rd_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      nackSeen_q <= nackSeen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ackErr_q   <= ackErr_d;
      rdata_q    <= rdata_d;
      sclOe_q    <= sclOe_d;
      sdaOe_q    <= sdaOe_d;
      sclSync_q  <= {sclSync_q[0], scl_i};
      sdaSync_q  <= {sdaSync_q[0], sda_i};
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ackErr_q;
  assign rdata   = rdata_q;
  assign scl_oe  = sclOe_q;
  assign sda_oe  = sdaOe_q;
endmodule

// File: tb/tb_pif_i2c_master.sv
// Directed bench for pif_i2c_master with a behavioural register-slave that
// ACKs, returns read data, logs bus bytes and can stretch SCL.
module tb_pif_i2c_master;
  localparam int CLK_DIV = 4;

  logic       xclk = 1'b0;
  logic       sys_rst;
  logic       cmd_start, cmd_rd;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  logic       scl_i, sda_i, scl_oe, sda_oe;

  typedef struct packed {
    bit        rd;
    bit [6:0]  dev;
    bit [7:0]  regAddr;
    bit [7:0]  wdata;
    bit [7:0]  slaveData;
    bit        present;
    bit        stretch;
    int        latMin;
    int        latMax;
    bit        expAckErr;
    bit [7:0]  expRdata;
    int        nBytes;
    bit [23:0] expBytes;
    int        starts;
    int        rises;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [6:0] slvAddr;
  logic       slvPresent;
  logic [7:0] slvData;
  logic       stretchOn;

  logic       sclHold     = 1'b0;
  logic       slaveSdaLow = 1'b0;
  int         holdCnt     = 0;
  int         releaseCnt  = 0;
  int         bitCnt      = 0;
  int         startCnt    = 0;
  int         stopCnt     = 0;
  int         riseCnt     = 0;
  logic       lastScl = 1'b1, lastSda = 1'b1, lastSclOe = 1'b0;
  logic       firstByte = 1'b0, addressed = 1'b0, readDir = 1'b0, txMode = 1'b0;
  logic       masterNackBit = 1'b0;
  logic [7:0] shiftIn = 8'h00, txBits = 8'h00;
  logic [7:0] busLog [$];

  pif_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .cmd_start(cmd_start), .cmd_rd(cmd_rd), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 xclk = ~xclk;

  assign scl_i = !(scl_oe || sclHold);
  assign sda_i = !(sda_oe || slaveSdaLow);

  // Slave and bus monitor, evaluated on the falling clock edge.
  always @(negedge xclk) begin : monitor
    logic scl, sda;
    if (sys_rst) begin
      holdCnt = 0; sclHold = 1'b0; slaveSdaLow = 1'b0; bitCnt = 0;
      lastScl = 1'b1; lastSda = 1'b1; lastSclOe = 1'b0; releaseCnt = 0;
      firstByte = 1'b0; addressed = 1'b0; readDir = 1'b0; txMode = 1'b0;
    end else begin
      if (holdCnt > 0) holdCnt--;
      if (lastSclOe && !scl_oe) begin
        releaseCnt++;
        if (stretchOn && releaseCnt == 18) holdCnt = 40;
      end
      lastSclOe = scl_oe;
      sclHold = (holdCnt > 0);
      scl = !(scl_oe || sclHold);
      sda = !(sda_oe || slaveSdaLow);
      if (lastScl && scl && lastSda && !sda) begin
        startCnt++; bitCnt = 0; firstByte = 1'b1; txMode = 1'b0;
        slaveSdaLow = 1'b0; releaseCnt = 0;
      end else if (lastScl && scl && !lastSda && sda) begin
        stopCnt++; addressed = 1'b0;
      end else if (!lastScl && scl) begin
        riseCnt++;
        if (bitCnt < 8) begin
          shiftIn = {shiftIn[6:0], sda};
          bitCnt++;
        end else begin
          if (txMode) masterNackBit = sda;
          bitCnt = 9;
        end
      end else if (lastScl && !scl) begin
        if (bitCnt == 8) begin
          if (!txMode) begin
            busLog.push_back(shiftIn);
            if (firstByte) begin
              addressed = slvPresent && (shiftIn[7:1] == slvAddr);
              readDir   = shiftIn[0];
              firstByte = 1'b0;
            end
            slaveSdaLow = addressed;
          end else begin
            slaveSdaLow = 1'b0;
          end
        end else if (bitCnt == 9) begin
          slaveSdaLow = 1'b0;
          bitCnt = 0;
          if (txMode) txMode = 1'b0;
          else if (addressed && readDir) begin
            txMode = 1'b1;
            txBits = slvData;
            slaveSdaLow = !txBits[7];
          end
        end else if (txMode && bitCnt > 0 && bitCnt < 8) begin
          slaveSdaLow = !txBits[7-bitCnt];
        end
      end
      lastScl = scl;
      lastSda = sda;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag, output int lat);
    slvAddr = v.dev; slvPresent = v.present; slvData = v.slaveData; stretchOn = v.stretch;
    @(negedge xclk);
    cmd_rd = v.rd; cmd_dev = v.dev; cmd_reg = v.regAddr; cmd_wdata = v.wdata;
    cmd_start = 1'b1;
    @(posedge xclk); #1;
    cmd_start = 1'b0;
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (lat < 2000 && !done) begin
      @(posedge xclk); #1;
      lat++;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int b0, s0, p0, r0, lat;
    logic [23:0] eb;
    logic [31:0] got;
    b0 = busLog.size(); s0 = startCnt; p0 = stopCnt; r0 = riseCnt;
    applyStimulus(v, tag, lat);
    checkRange({tag, "_latency"}, lat, v.latMin, v.latMax);
    checkOutput({tag, "_ackerr"}, {31'd0, ack_err}, {31'd0, v.expAckErr});
    checkOutput({tag, "_rdata"}, {24'd0, rdata}, {24'd0, v.expRdata});
    repeat (20) @(posedge xclk);
    #1;
    checkOutput({tag, "_busyidle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_nbytes"}, busLog.size() - b0, v.nBytes);
    eb = v.expBytes;
    for (int k = 0; k < v.nBytes; k++) begin
      got = (b0 + k < busLog.size()) ? {24'd0, busLog[b0+k]} : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_byte%0d", tag, k), got, {24'd0, eb[23-8*k -: 8]});
    end
    checkOutput({tag, "_starts"}, startCnt - s0, v.starts);
    checkOutput({tag, "_stops"}, stopCnt - p0, 1);
    checkOutput({tag, "_sclrises"}, riseCnt - r0, v.rises);
    if (v.rd) checkOutput({tag, "_mnack"}, {31'd0, masterNackBit}, 32'd1);
  endtask

  initial begin
    vec_t vecs [5];
    vec_t v;
    int doneCnt, firstDone, waited;

    // rd dev reg wdata sdata pres str latMin latMax ackErr rdata nB bytes starts rises
    vecs[0] = '{1'b0, 7'h41, 8'h02, 8'h01, 8'h00, 1'b1, 1'b0, 465, 465, 1'b0, 8'h00, 3, 24'h820201, 1, 28};
    vecs[1] = '{1'b1, 7'h41, 8'h05, 8'h00, 8'hA5, 1'b1, 1'b0, 625, 625, 1'b0, 8'hA5, 3, 24'h820583, 2, 38};
    vecs[2] = '{1'b1, 7'h2C, 8'h80, 8'h00, 8'h3C, 1'b1, 1'b0, 625, 625, 1'b0, 8'h3C, 3, 24'h588059, 2, 38};
    vecs[3] = '{1'b0, 7'h41, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, 177, 177, 1'b1, 8'h3C, 1, 24'h820000, 1, 10};
    vecs[4] = '{1'b0, 7'h41, 8'h03, 8'h5A, 8'h00, 1'b1, 1'b1, 503, 507, 1'b0, 8'h3C, 3, 24'h82035A, 1, 28};

    sys_rst = 1'b1; cmd_start = 1'b0; cmd_rd = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_wdata = '0;
    slvAddr = '0; slvPresent = 1'b0; slvData = '0; stretchOn = 1'b0;
    repeat (3) @(posedge xclk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ackerr", {31'd0, ack_err}, 32'd0);
    checkOutput("rst_rdata", {24'd0, rdata}, 32'd0);
    checkOutput("rst_scloe", {31'd0, scl_oe}, 32'd0);
    checkOutput("rst_sdaoe", {31'd0, sda_oe}, 32'd0);
    @(negedge xclk);
    sys_rst = 1'b0;
    repeat (4) @(posedge xclk);

    for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("v%0d", i));

    // Second cmd_start mid-write must be ignored.
    stretchOn = 1'b0; slvAddr = 7'h41; slvPresent = 1'b1;
    begin
      int b0, s0, r0;
      b0 = busLog.size(); s0 = startCnt; r0 = riseCnt;
      @(negedge xclk);
      cmd_rd = 1'b0; cmd_dev = 7'h41; cmd_reg = 8'h02; cmd_wdata = 8'h01; cmd_start = 1'b1;
      @(posedge xclk); #1;
      cmd_start = 1'b0;
      doneCnt = 0; firstDone = -1;
      for (int c = 1; c <= 600; c++) begin
        if (c == 100) begin
          cmd_rd = 1'b1; cmd_dev = 7'h10; cmd_reg = 8'h77; cmd_wdata = 8'hFF; cmd_start = 1'b1;
        end
        @(posedge xclk); #1;
        if (c == 100) cmd_start = 1'b0;
        if (done) begin
          doneCnt++;
          if (firstDone < 0) firstDone = c;
        end
      end
      checkOutput("dup_donecnt", doneCnt, 1);
      checkOutput("dup_latency", firstDone, 465);
      checkOutput("dup_nbytes", busLog.size() - b0, 3);
      checkOutput("dup_byte0", (busLog.size() > b0) ? {24'd0, busLog[b0]} : 32'hFFFF_FFFF, 32'h82);
      checkOutput("dup_byte1", (busLog.size() > b0 + 1) ? {24'd0, busLog[b0+1]} : 32'hFFFF_FFFF, 32'h02);
      checkOutput("dup_byte2", (busLog.size() > b0 + 2) ? {24'd0, busLog[b0+2]} : 32'hFFFF_FFFF, 32'h01);
      checkOutput("dup_starts", startCnt - s0, 1);
      checkOutput("dup_sclrises", riseCnt - r0, 28);
      checkOutput("dup_ackerr", {31'd0, ack_err}, 32'd0);
    end

    // Reset while the data byte is on the bus, with both lines pulled low.
    @(negedge xclk);
    cmd_rd = 1'b0; cmd_dev = 7'h41; cmd_reg = 8'h02; cmd_wdata = 8'h01; cmd_start = 1'b1;
    @(posedge xclk); #1;
    cmd_start = 1'b0;
    repeat (310) @(posedge xclk);
    #1;
    waited = 0;
    while (waited < 40 && !(scl_oe && sda_oe)) begin
      @(posedge xclk); #1;
      waited++;
    end
    checkOutput("rstmid_found", {31'd0, scl_oe && sda_oe}, 32'd1);
    @(negedge xclk);
    sys_rst = 1'b1;
    #1;
    checkOutput("rstmid_scloe", {31'd0, scl_oe}, 32'd0);
    checkOutput("rstmid_sdaoe", {31'd0, sda_oe}, 32'd0);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_rdata", {24'd0, rdata}, 32'd0);
    checkOutput("rstmid_ackerr", {31'd0, ack_err}, 32'd0);
    repeat (3) @(negedge xclk);
    sys_rst = 1'b0;
    repeat (4) @(posedge xclk);
    v = vecs[0];
    v.expRdata = 8'h00;
    runVector(v, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
